// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and forwarding select codes for the pipeline controller
package pipe_pkg;
  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/fwd_sel.sv
// fwd_sel: picks the EX operand source, MEM result over WB result; loads in MEM are not forwardable
module fwd_sel
  import pipe_pkg::*;
(
  input  logic [4:0] src,
  input  logic [4:0] mem_addr,
  input  logic       mem_regwrite,
  input  logic       mem_memtoreg,
  input  logic [4:0] wb_addr,
  input  logic       wb_regwrite,
  output logic [1:0] sel
);
  always_comb
    sel = (mem_regwrite && !mem_memtoreg && mem_addr != REG_ZERO && mem_addr == src) ? FWD_MEM :
          (wb_regwrite && wb_addr != REG_ZERO && wb_addr == src) ? FWD_WB : FWD_REG;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stage enables/flushes, forwarding selects, dmem wait FSM with timeout and stall counter
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       ex_addr,
  input  logic             ex_regwrite,
  input  logic             ex_memtoreg,
  input  logic             ex_branch_taken,
  input  logic [4:0]       mem_addr,
  input  logic             mem_regwrite,
  input  logic             mem_memtoreg,
  input  logic             mem_memwrite,
  input  logic [4:0]       wb_addr,
  input  logic             wb_regwrite,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             dmem_req,
  output logic             err,
  output logic [CNT_W-1:0] stall_cycles
);
  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_nxt;
  logic [1:0] sel_a, sel_b;
  logic       mem_access, load_use;
  assign mem_access = mem_memtoreg | mem_memwrite;
  assign load_use = ex_memtoreg && ex_regwrite && ex_addr != REG_ZERO &&
                    ((id_uses_rs && id_rs == ex_addr) || (id_uses_rt && id_rt == ex_addr));
  fwd_sel u_fwd_a (
    .src(ex_rs), .mem_addr(mem_addr), .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg),
    .wb_addr(wb_addr), .wb_regwrite(wb_regwrite), .sel(sel_a)
  );
  fwd_sel u_fwd_b (
    .src(ex_rt), .mem_addr(mem_addr), .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg),
    .wb_addr(wb_addr), .wb_regwrite(wb_regwrite), .sel(sel_b)
  );
  assign fwd_a = rst_n ? sel_a : FWD_REG;
  assign fwd_b = rst_n ? sel_b : FWD_REG;
  // wait_cnt counts MEM_WAIT cycles; HALT after TIMEOUT of them without ready
  always_comb begin
    state_nxt   = state;
    wait_nxt    = wait_cnt;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    dmem_req    = mem_access && state != HALT;
    if (!rst_n) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
      dmem_req    = 1'b0;
    end else if (state == HALT) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (mem_access && !dmem_ready) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
      state_nxt   = (state == MEM_WAIT && wait_cnt == 8'(TIMEOUT - 1)) ? HALT : MEM_WAIT;
      wait_nxt    = state == RUN ? 8'd0 : wait_cnt + 8'd1;
    end else begin
      state_nxt = RUN;
      if (ex_branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= RUN;
      wait_cnt     <= '0;
      err          <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      err      <= err | (state_nxt == HALT);
      if (!pc_en && stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline controller for the 5-stage core. It drives the enable and flush inputs of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers, and produces the EX-stage forwarding selects. It resolves load-use hazards, taken-branch flushes and data-memory wait states. A small FSM, a wait-timeout counter and a saturating stall-cycle counter give it registered state.

## Interface
- TIMEOUT, 15: max consecutive dmem wait cycles before HALT (1..255)
- CNT_W, 16: width of stall_cycles counter

- clk  in  1  core clock, all state on posedge
- rst_n  in  1  synchronous, active-low reset
- id_rs, id_rt  in  5 each  source regs of instr in ID
- id_uses_rs, id_uses_rt  in  1 each  ID instr actually reads rs/rt
- ex_rs, ex_rt  in  5 each  source regs of instr in EX
- ex_addr  in  5  dest reg in EX
- ex_regwrite, ex_memtoreg  in  1 each  EX instr writes reg / is load
- ex_branch_taken  in  1  branch/jump resolved taken in EX
- mem_addr  in  5  dest reg in MEM
- mem_regwrite, mem_memtoreg, mem_memwrite  in  1 each  MEM-stage controls
- wb_addr  in  5  dest reg in WB
- wb_regwrite  in  1  WB-stage control
- dmem_ready  in  1  data memory completes access this cycle
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register load enables
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  load bubble (all controls 0) instead of data
- fwd_a, fwd_b  out  2 each  ALU operand select: 00 regfile, 01 WB, 10 MEM
- dmem_req  out  1  MEM stage needs memory
- err  out  1  sticky timeout flag
- stall_cycles  out  CNT_W  saturating count of cycles with pc_en=0

## Operation
- FSM states: RUN, MEM_WAIT, HALT.
- dmem_req = (mem_memtoreg | mem_memwrite) in RUN and MEM_WAIT; 0 in HALT.
- Load-use hazard is true when all of the following hold:
  - ex_memtoreg & ex_regwrite & ex_addr != 0;
  - (id_uses_rs & id_rs == ex_addr) | (id_uses_rt & id_rt == ex_addr).
- Priority within a cycle: HALT > memory wait > branch > load-use > normal.
- RUN, dmem_req & !dmem_ready:
  - go to MEM_WAIT;
  - pc/ifid/idex/exmem enables 0;
  - memwb_en=1, memwb_flush=1.
- RUN, branch taken:
  - all enables 1;
  - ifid_flush=1, idex_flush=1.
  - A load-use hazard in the same cycle is ignored, because the ID instr is wrong-path.
- RUN, load-use:
  - pc_en=0, ifid_en=0;
  - idex_en=1, idex_flush=1;
  - exmem and memwb enabled.
- RUN, normal: all enables 1, no flushes.
- MEM_WAIT:
  - identical freeze outputs to the memory-wait case above;
  - wait_cnt increments each cycle.
  - dmem_ready → RUN. Outputs in that cycle follow the RUN rules, so a pending branch or load-use is honoured then.
  - wait_cnt reaching TIMEOUT without ready → HALT.
- HALT:
  - all enables 0, no flushes, dmem_req=0;
  - err=1;
  - exit only via reset.
- Forwarding (fwd_a for ex_rs, fwd_b for ex_rt):
  - 10 if mem_regwrite & !mem_memtoreg & mem_addr != 0 & match;
  - else 01 if wb_regwrite & wb_addr != 0 & match;
  - else 00.
  - Register 0 is never forwarded.
- stall_cycles increments on every cycle with pc_en=0 (including HALT) and saturates at all-ones.

## Timing
- All enable, flush, forwarding and dmem_req outputs are combinational from the current state and inputs (Mealy), with zero latency.
- state, wait_cnt, err and stall_cycles are registered.
- Reset (rst_n=0 at posedge) sets: state RUN, wait_cnt 0, err 0, stall_cycles 0.
- While rst_n=0, outputs are forced to:
  - all *_en=1 and all *_flush=1, so bubbles clear every stage register;
  - fwd 00, dmem_req 0.
- Reset asserted in MEM_WAIT or HALT returns to RUN on the next edge. The abandoned access is not retried.
- A zero-wait access (ready in the same cycle as req) costs no stall.
- Load-use costs exactly 1 bubble.
- A taken branch costs 2 flushed slots.
- wait_cnt is cleared on every entry to MEM_WAIT.

## Structure
- Shared package pipe_pkg holds:
  - state enum {RUN, MEM_WAIT, HALT};
  - FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - REG_ZERO=5'd0.
- One combinational sub-module, fwd_sel, is instantiated twice (for rs and rt). The FSM and counters live in pipe_ctrl.

## Test plan
- Load-use:
  - stimulus: lw $8 in EX (ex_memtoreg=1, ex_addr=8); add in ID with id_rs=8;
  - required: one cycle with pc_en=0, ifid_en=0, idex_flush=1; next cycle normal; stall_cycles=1.
- Forwarding priority:
  - stimulus: mem_addr=wb_addr=ex_rs=5, both regwrite;
  - required: fwd_a=10.
  - With mem_memtoreg=1 instead, required: fwd_a=01.
  - With addr=0, required: fwd_a=00.
- Branch + load-use together:
  - stimulus: ex_branch_taken=1 with a hazard present;
  - required: pc_en=1, ifid_flush=1, idex_flush=1.
- Memory wait:
  - stimulus: mem_memwrite=1, dmem_ready low for 3 cycles;
  - required: 3 frozen cycles with memwb_flush=1, then RUN; stall_cycles=3.
- Timeout:
  - stimulus: dmem_ready held 0 with TIMEOUT=15;
  - required: HALT after 15 wait cycles, err=1, dmem_req=0, all enables 0.
  - Then rst_n=0 for 1 cycle; required: RUN, err=0.
- Counter saturation:
  - stimulus: CNT_W=4, 20 stall cycles;
  - required: stall_cycles=15.
